// File: rtl/rv_seq_ctrl.sv
// -----------------------------------------------------------------------------
// rv_seq_ctrl -- multicycle instruction sequencer for an RV32I integer core.
//
// Fetches one instruction per pass over a req/ack instruction-memory
// handshake, holds it in the instruction register, classifies it, programs
// the ALU controls, starts and waits on the execute unit, pulses the
// register-file write enable and advances the PC. Unsupported encodings and
// execute-unit timeouts park the sequencer in a terminal TRAP state that only
// reset leaves.
//
// Optional feature: define RV_SEQ_CTRL_MEXT_EN to accept RV32M R-type
// encodings (func7 = 0000001). Without it those encodings trap as illegal
// and m_sel is tied low.
//
// Parameters:
//   RESET_PC    PC value loaded on reset.
//   EX_TIMEOUT  EXEC cycles allowed before ex_done must arrive (2..255).
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   imem_req          instruction fetch request, held until imem_ack
//   imem_addr         fetch address, always equal to pc
//   imem_ack          fetch data valid this cycle
//   imem_rdata        fetched instruction word
//   ir                instruction register, feeds the field decoders
//   pc                current program counter
//   alu_op            ALU operation code
//   alu_src_imm       1 = second ALU operand is the I-type immediate
//   m_sel             RV32M operation select
//   ex_start          one-cycle execute start pulse
//   ex_done           execute unit result ready
//   rf_we             register-file write enable, one-cycle pulse
//   illegal, timeout  sticky trap flags
//   instret           retired-instruction counter
// -----------------------------------------------------------------------------
module rv_seq_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned EX_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [31:0] pc,
  output logic [3:0]  alu_op,
  output logic        alu_src_imm,
  output logic        m_sel,
  output logic        ex_start,
  input  logic        ex_done,
  output logic        rf_we,
  output logic        illegal,
  output logic        timeout,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_TRAP
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
`ifdef RV_SEQ_CTRL_MEXT_EN
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;
`endif

  localparam logic [7:0] EX_LIMIT = 8'(EX_TIMEOUT);

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] instret_q, instret_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic        alu_src_imm_q, alu_src_imm_d;
  logic        imem_req_q, imem_req_d;
  logic        ex_start_q, ex_start_d;
  logic        rf_we_q, rf_we_d;
  logic        illegal_q, illegal_d;
  logic        timeout_q, timeout_d;
  // Number of the current EXEC cycle, 1 on the ex_start cycle.
  logic [7:0]  ex_cnt_q, ex_cnt_d;
`ifdef RV_SEQ_CTRL_MEXT_EN
  logic        m_sel_q, m_sel_d;
`endif

  // ---------------------------------------------------------------------------
  // Instruction classification, evaluated on the held instruction register
  // ---------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       dec_legal;
  logic [3:0] dec_alu_op;
  logic       dec_src_imm;
`ifdef RV_SEQ_CTRL_MEXT_EN
  logic       dec_m_sel;
`endif

  assign opcode = ir_q[6:0];
  assign func3  = ir_q[14:12];
  assign func7  = ir_q[31:25];

  // NOTE: every signal written in an always_comb gets a default at the top so
  // no path through the case/if tree leaves it unassigned (which would infer
  // a latch).
  always_comb begin
    dec_legal   = 1'b0;
    dec_alu_op  = 4'b0000;
    dec_src_imm = 1'b0;
`ifdef RV_SEQ_CTRL_MEXT_EN
    dec_m_sel   = 1'b0;
`endif
    case (opcode)
      OPC_OP: begin
        if (func7 == F7_BASE) begin
          dec_legal  = 1'b1;
          dec_alu_op = {1'b0, func3};
        end else if (func7 == F7_ALT && (func3 == 3'b000 || func3 == 3'b101)) begin
          // SUB and SRA: func7[5] selects the alternate operation.
          dec_legal  = 1'b1;
          dec_alu_op = {1'b1, func3};
`ifdef RV_SEQ_CTRL_MEXT_EN
        end else if (func7 == F7_MULDIV) begin
          dec_legal  = 1'b1;
          dec_alu_op = {1'b0, func3};
          dec_m_sel  = 1'b1;
`endif
        end
      end
      OPC_OP_IMM: begin
        dec_src_imm = 1'b1;
        // Only the shift-right group uses ir[30] (SRAI); for every other
        // func3 that bit is ordinary immediate data.
        dec_alu_op  = {ir_q[30] & (func3 == 3'b101), func3};
        case (func3)
          3'b001:  dec_legal = (func7 == F7_BASE);
          3'b101:  dec_legal = (func7 == F7_BASE) || (func7 == F7_ALT);
          default: dec_legal = 1'b1;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic. Outputs are computed for the state being
  // entered so that every port comes straight from a flop.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    instret_d     = instret_q;
    alu_op_d      = alu_op_q;
    alu_src_imm_d = alu_src_imm_q;
    imem_req_d    = imem_req_q;
    ex_start_d    = 1'b0;
    rf_we_d       = 1'b0;
    illegal_d     = illegal_q;
    timeout_d     = timeout_q;
    ex_cnt_d      = ex_cnt_q;
`ifdef RV_SEQ_CTRL_MEXT_EN
    m_sel_d       = m_sel_q;
`endif

    case (state_q)
      S_IDLE: begin
        state_d    = S_FETCH;
        imem_req_d = 1'b1;
      end

      S_FETCH: begin
        // An ack only counts while our own request is up.
        if (imem_ack && imem_req_q) begin
          ir_d       = imem_rdata;
          imem_req_d = 1'b0;
          state_d    = S_DECODE;
        end
      end

      S_DECODE: begin
        if (dec_legal) begin
          alu_op_d      = dec_alu_op;
          alu_src_imm_d = dec_src_imm;
`ifdef RV_SEQ_CTRL_MEXT_EN
          m_sel_d       = dec_m_sel;
`endif
          ex_start_d    = 1'b1;
          ex_cnt_d      = 8'd1;
          state_d       = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end
      end

      S_EXEC: begin
        // ex_done is not trusted in the start cycle. Checking it ahead of the
        // limit lets a result arriving on the last allowed cycle still retire.
        if (ex_done && !ex_start_q) begin
          rf_we_d = (ir_q[11:7] != 5'd0);
          state_d = S_WB;
        end else if (ex_cnt_q == EX_LIMIT) begin
          timeout_d = 1'b1;
          state_d   = S_TRAP;
        end else begin
          ex_cnt_d = ex_cnt_q + 8'd1;
        end
      end

      S_WB: begin
        pc_d       = pc_q + 32'd4;
        instret_d  = instret_q + 32'd1;
        imem_req_d = 1'b1;
        state_d    = S_FETCH;
      end

      S_TRAP: begin
        imem_req_d = 1'b0;
        state_d    = S_TRAP;
      end

      default: begin
        imem_req_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      ir_q          <= '0;
      instret_q     <= '0;
      alu_op_q      <= '0;
      alu_src_imm_q <= 1'b0;
      imem_req_q    <= 1'b0;
      ex_start_q    <= 1'b0;
      rf_we_q       <= 1'b0;
      illegal_q     <= 1'b0;
      timeout_q     <= 1'b0;
      ex_cnt_q      <= '0;
`ifdef RV_SEQ_CTRL_MEXT_EN
      m_sel_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      instret_q     <= instret_d;
      alu_op_q      <= alu_op_d;
      alu_src_imm_q <= alu_src_imm_d;
      imem_req_q    <= imem_req_d;
      ex_start_q    <= ex_start_d;
      rf_we_q       <= rf_we_d;
      illegal_q     <= illegal_d;
      timeout_q     <= timeout_d;
      ex_cnt_q      <= ex_cnt_d;
`ifdef RV_SEQ_CTRL_MEXT_EN
      m_sel_q       <= m_sel_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign ir          = ir_q;
  assign pc          = pc_q;
  assign alu_op      = alu_op_q;
  assign alu_src_imm = alu_src_imm_q;
  assign ex_start    = ex_start_q;
  assign rf_we       = rf_we_q;
  assign illegal     = illegal_q;
  assign timeout     = timeout_q;
  assign instret     = instret_q;
`ifdef RV_SEQ_CTRL_MEXT_EN
  assign m_sel       = m_sel_q;
`else
  assign m_sel       = 1'b0;
`endif

endmodule

// File: tb/tb_rv_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rv_seq_ctrl -- self-checking bench for rv_seq_ctrl.
//
// The bench plays instruction memory and execute unit from a directed script.
// For each instruction the model derives the decode result from the ISA field
// rules and lays out the cycle timeline (fetch wait, decode, exec, write-back
// or trap); a compare process checks every DUT output against that
// expectation on each falling edge. A second instance with RESET_PC near the
// top of the address space checks PC wrap-around on the same stimulus.
// -----------------------------------------------------------------------------
module tb_rv_seq_ctrl;

  localparam int          TMO       = 16;
  localparam logic [31:0] WRAP_BASE = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        ex_done;

  logic        imem_req, alu_src_imm, m_sel, ex_start, rf_we, illegal, timeout;
  logic [31:0] imem_addr, ir, pc, instret;
  logic [3:0]  alu_op;

  logic        imem_req_w, alu_src_imm_w, m_sel_w, ex_start_w, rf_we_w, illegal_w, timeout_w;
  logic [31:0] imem_addr_w, ir_w, pc_w, instret_w;
  logic [3:0]  alu_op_w;

  always #5 clk = ~clk;

  rv_seq_ctrl #(.RESET_PC(32'h0000_0000), .EX_TIMEOUT(TMO)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir(ir), .pc(pc), .alu_op(alu_op), .alu_src_imm(alu_src_imm), .m_sel(m_sel),
    .ex_start(ex_start), .ex_done(ex_done), .rf_we(rf_we),
    .illegal(illegal), .timeout(timeout), .instret(instret)
  );

  rv_seq_ctrl #(.RESET_PC(WRAP_BASE), .EX_TIMEOUT(TMO)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir(ir_w), .pc(pc_w), .alu_op(alu_op_w), .alu_src_imm(alu_src_imm_w), .m_sel(m_sel_w),
    .ex_start(ex_start_w), .ex_done(ex_done), .rf_we(rf_we_w),
    .illegal(illegal_w), .timeout(timeout_w), .instret(instret_w)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int rf_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: architectural state plus the expectation for the current cycle
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic        imem_req;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] instret;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic        m_sel;
    logic        ex_start;
    logic        rf_we;
    logic        illegal;
    logic        timeout;
    logic        chk_alu;
  } exp_t;

  exp_t        expv;
  bit          chk_en = 1'b0;
  logic [31:0] m_pc, m_ir, m_instret;
  logic [3:0]  m_alu_op;
  logic        m_src, m_msel, m_illegal, m_timeout;

  function automatic exp_t mk(input logic req, input logic start, input logic we, input logic ca);
    exp_t e;
    e.imem_req    = req;
    e.pc          = m_pc;
    e.ir          = m_ir;
    e.instret     = m_instret;
    e.alu_op      = m_alu_op;
    e.alu_src_imm = m_src;
    e.m_sel       = m_msel;
    e.ex_start    = start;
    e.rf_we       = we;
    e.illegal     = m_illegal;
    e.timeout     = m_timeout;
    e.chk_alu     = ca;
    return e;
  endfunction

  // ISA rules for the supported subset.
  function automatic void isa_decode(input logic [31:0] w, output bit legal,
                                     output logic [3:0] op, output bit imm, output bit msel);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    legal = 1'b0; op = 4'd0; imm = 1'b0; msel = 1'b0;
    if (opc == 7'b0110011) begin
      if (f7 == 7'h00) begin legal = 1'b1; op = {1'b0, f3}; end
      else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin legal = 1'b1; op = {1'b1, f3}; end
`ifdef RV_SEQ_CTRL_MEXT_EN
      else if (f7 == 7'h01) begin legal = 1'b1; op = {1'b0, f3}; msel = 1'b1; end
`endif
    end else if (opc == 7'b0010011) begin
      imm = 1'b1;
      op  = {(f3 == 3'd5) && w[30], f3};
      if (f3 == 3'd1)      legal = (f7 == 7'h00);
      else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
      else                 legal = 1'b1;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Compare process: every falling edge while checking is enabled
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_req",   32'(imem_req),  32'(expv.imem_req));
      check("imem_addr",  imem_addr,      expv.pc);
      check("pc",         pc,             expv.pc);
      check("pc_wrap",    pc_w,           expv.pc + WRAP_BASE);
      check("addr_wrap",  imem_addr_w,    expv.pc + WRAP_BASE);
      check("ir",         ir,             expv.ir);
      check("instret",    instret,        expv.instret);
      check("ex_start",   32'(ex_start),  32'(expv.ex_start));
      check("rf_we",      32'(rf_we),     32'(expv.rf_we));
      check("illegal",    32'(illegal),   32'(expv.illegal));
      check("timeout",    32'(timeout),   32'(expv.timeout));
      if (expv.chk_alu) begin
        check("alu_op",      32'(alu_op),      32'(expv.alu_op));
        check("alu_src_imm", 32'(alu_src_imm), 32'(expv.alu_src_imm));
        check("m_sel",       32'(m_sel),       32'(expv.m_sel));
      end
    end
  end

  // Captures of DUT behaviour used by the literal checks.
  logic [3:0] cap_alu_op;
  logic       cap_src, cap_msel;
  always @(negedge clk) begin
    if (rst_n && rf_we) rf_pulses++;
    if (rst_n && ex_start) begin
      cap_alu_op = alu_op;
      cap_src    = alu_src_imm;
      cap_msel   = m_sel;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic step(input logic ack, input logic [31:0] rdata, input logic done, input exp_t e);
    expv       = e;
    imem_ack   = ack;
    imem_rdata = rdata;
    ex_done    = done;
    chk_en     = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    chk_en     = 1'b0;
    rst_n      = 1'b0;
    imem_ack   = 1'b1;
    ex_done    = 1'b1;
    imem_rdata = 32'h0050_0013;
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    m_pc      = 32'h0;
    m_ir      = 32'h0;
    m_instret = 32'h0;
    m_alu_op  = 4'd0;
    m_src     = 1'b0;
    m_msel    = 1'b0;
    m_illegal = 1'b0;
    m_timeout = 1'b0;
    // IDLE cycle: stale ack and done are still high and must be ignored.
    step(1'b1, 32'h0050_0013, 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b1));
  endtask

  // ack_at: fetch cycle carrying imem_ack (1 = same cycle as the request).
  // done_at: EXEC cycle carrying ex_done (0 = never). early: ex_done also
  // high in the ex_start cycle.
  task automatic run_instr(input logic [31:0] w, input int ack_at, input int done_at,
                           input bit early, output bit trapped);
    bit         legal, imm, msel;
    logic [3:0] op;
    isa_decode(w, legal, op, imm, msel);
    trapped = 1'b0;
    for (int i = 1; i <= ack_at; i++)
      step(i == ack_at, (i == ack_at) ? w : (32'hDEAD_BEEF ^ 32'(i)), i != ack_at,
           mk(1'b1, 1'b0, 1'b0, 1'b0));
    m_ir = w;
    // Decode cycle: a stray ack with the request down must not reload ir.
    step(1'b1, 32'hFFFF_FFFF, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0));
    if (!legal) begin
      m_illegal = 1'b1;
      trapped   = 1'b1;
      return;
    end
    m_alu_op = op;
    m_src    = imm;
    m_msel   = msel;
    for (int k = 1; k <= TMO; k++) begin
      step(1'b0, 32'h0, (k == 1) ? early : (k == done_at), mk(1'b0, k == 1, 1'b0, 1'b1));
      if (k >= 2 && k == done_at) break;
      if (k == TMO) begin
        m_timeout = 1'b1;
        trapped   = 1'b1;
        return;
      end
    end
    step(1'b0, 32'h0, 1'b0, mk(1'b0, 1'b0, w[11:7] != 5'd0, 1'b1));
    m_pc      = m_pc + 32'd4;
    m_instret = m_instret + 32'd1;
  endtask

  task automatic trap_hold(input int n);
    for (int i = 0; i < n; i++)
      step(i % 2 == 0, 32'h1234_0000 + 32'(i), i % 2 == 1, mk(1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  // ---------------------------------------------------------------------------
  // Directed program
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] w;
    int          ack_at;
    int          done_at;
    bit          early;
  } vec_t;

  vec_t vecs[16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, n_errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit trapped;
    int c0;
    int pulses0;

    vecs[0]  = '{32'h0020_81B3, 2, 2, 1'b0};   // add  x3,x1,x2
    vecs[1]  = '{32'h0050_0013, 1, 3, 1'b1};   // addi x0,x0,5
    vecs[2]  = '{32'h4032_D293, 1, 2, 1'b0};   // srai x5,x5,3
    vecs[3]  = '{32'h4020_81B3, 3, 2, 1'b0};   // sub
    vecs[4]  = '{32'h4020_D1B3, 1, 4, 1'b0};   // sra
    vecs[5]  = '{32'h0FF1_4093, 1, 2, 1'b0};   // xori x1,x2,255
    vecs[6]  = '{32'hC001_7093, 2, 2, 1'b0};   // andi x1,x2,-1024 (ir[30]=1)
    vecs[7]  = '{32'h0020_82B3, 1, TMO, 1'b0}; // add, ex_done on the last allowed cycle
    vecs[8]  = '{32'h0032_9293, 1, 2, 1'b0};   // slli
    vecs[9]  = '{32'h0032_D293, 2, 3, 1'b0};   // srli
    vecs[10] = '{32'h0020_E1B3, 1, 2, 1'b0};   // or
    vecs[11] = '{32'h0020_91B3, 1, 2, 1'b0};   // sll
    vecs[12] = '{32'h0020_A1B3, 1, 5, 1'b0};   // slt
    vecs[13] = '{32'h0010_B393, 1, 2, 1'b0};   // sltiu x7,x1,1
`ifdef RV_SEQ_CTRL_MEXT_EN
    vecs[14] = '{32'h0220_81B3, 1, 2, 1'b0};   // mul
`else
    vecs[14] = '{32'h0020_F1B3, 1, 2, 1'b0};   // and
`endif
    vecs[15] = '{32'h0020_B1B3, 1, 2, 1'b0};   // sltu

    imem_ack = 1'b0; imem_rdata = 32'h0; ex_done = 1'b0; rst_n = 1'b0;
    do_reset();

    // ---- Phase A: sixteen retirements, pc 0 -> 0x40 ----
    for (int n = 0; n < 16; n++) begin
      c0 = cyc;
      pulses0 = rf_pulses;
      run_instr(vecs[n].w, vecs[n].ack_at, vecs[n].done_at, vecs[n].early, trapped);
      check("phaseA_no_trap", 32'(trapped), 32'd0);
      if (n == 0) begin
        check("add_latency",   32'(cyc - c0),      32'd6);
        check("add_pc",        pc,                 32'h0000_0004);
        check("add_instret",   instret,            32'd1);
        check("add_alu_op",    32'(cap_alu_op),    32'h0);
        check("add_src_imm",   32'(cap_src),       32'h0);
        check("add_rf_pulses", 32'(rf_pulses),     32'd1);
      end
      if (n == 1) begin
        check("addi_src_imm",  32'(cap_src),       32'h1);
        check("addi_alu_op",   32'(cap_alu_op),    32'h0);
        check("addi_no_rf_we", 32'(rf_pulses),     32'(pulses0));
        check("addi_pc",       pc,                 32'h0000_0008);
        check("wrap_pc_zero",  pc_w,               32'h0000_0000);
      end
      if (n == 2) check("srai_alu_op", 32'(cap_alu_op), 32'hD);
      if (n == 6) check("andi_alu_op", 32'(cap_alu_op), 32'h7);
      if (n == 7) check("done_at_limit_instret", instret, 32'd8);
`ifdef RV_SEQ_CTRL_MEXT_EN
      if (n == 14) begin
        check("mul_m_sel",  32'(cap_msel),   32'h1);
        check("mul_alu_op", 32'(cap_alu_op), 32'h0);
      end
`endif
    end
    check("phaseA_pc", pc, 32'h0000_0040);

    // ---- Reset in the middle of a fetch ----
    step(1'b0, 32'h0, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0));
    chk_en     = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h0020_81B3;
    check("pre_reset_req", 32'(imem_req), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_pc",        pc,                32'h0000_0000);
    check("rst_addr",      imem_addr,         32'h0000_0000);
    check("rst_pc_wrap",   pc_w,              WRAP_BASE);
    check("rst_req",       32'(imem_req),     32'h0);
    check("rst_ir",        ir,                32'h0);
    check("rst_alu_op",    32'(alu_op),       32'h0);
    check("rst_src_imm",   32'(alu_src_imm),  32'h0);
    check("rst_m_sel",     32'(m_sel),        32'h0);
    check("rst_ex_start",  32'(ex_start),     32'h0);
    check("rst_rf_we",     32'(rf_we),        32'h0);
    check("rst_flags",     {30'd0, illegal, timeout}, 32'h0);
    check("rst_instret",   instret,           32'h0);
    do_reset();
    check("post_idle_req",  32'(imem_req), 32'h1);
    check("post_idle_addr", imem_addr,     32'h0000_0000);

    // ---- Illegal slli after one retirement: pc frozen at 4 ----
    run_instr(32'h0050_0013, 1, 2, 1'b0, trapped);
    run_instr(32'h4032_9293, 3, 2, 1'b0, trapped);
    check("slli_trapped", 32'(trapped), 32'h1);
    trap_hold(6);
    check("slli_illegal", 32'(illegal), 32'h1);
    check("slli_pc",      pc,           32'h0000_0004);
    check("slli_ir",      ir,           32'h4032_9293);

    // ---- jal, R-type bad func7/func3 pair, srli with bad func7 ----
    do_reset();
    run_instr(32'h0000_006F, 1, 2, 1'b0, trapped);
    trap_hold(3);
    check("jal_illegal", 32'(illegal), 32'h1);
    do_reset();
    run_instr(32'h4020_C1B3, 2, 2, 1'b0, trapped);
    trap_hold(2);
    do_reset();
    run_instr(32'h0232_D293, 1, 2, 1'b0, trapped);
    trap_hold(2);

    // ---- mul: legal only with the M extension ----
    do_reset();
    run_instr(32'h0220_81B3, 1, 2, 1'b0, trapped);
`ifdef RV_SEQ_CTRL_MEXT_EN
    check("mul_retired", instret, 32'd1);
`else
    trap_hold(2);
    check("mul_illegal", 32'(illegal), 32'h1);
`endif

    // ---- Execute timeout ----
    do_reset();
    c0 = cyc;
    run_instr(32'h0020_81B3, 1, 0, 1'b0, trapped);
    check("tmo_latency", 32'(cyc - c0), 32'd18);
    check("tmo_flag",    32'(timeout),  32'h1);
    trap_hold(3);
    check("tmo_not_illegal", 32'(illegal), 32'h0);
    check("tmo_pc",          pc,           32'h0000_0000);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
